// File: rtl/lsu_dmem_ctrl_if.sv
// Core-side request/response and DMEM-side signals of the load/store unit.
// slave: seen by the LSU; master: seen by the core and DMEM around it.
interface lsu_dmem_ctrl_if #(
  parameter int AW = 32
);
  logic          Req;
  logic          WE;
  logic [2:0]    Funct3;
  logic [AW-1:0] Addr;
  logic [31:0]   WData;
  logic          Ready;
  logic          Done;
  logic          Fault;
  logic [31:0]   RData;
  logic [AW-1:0] Mem_Addr;
  logic [31:0]   Mem_DataW;
  logic          Mem_RW;
  logic [31:0]   Mem_DataR;

  modport slave (
    input  Req, WE, Funct3, Addr, WData, Mem_DataR,
    output Ready, Done, Fault, RData,
    output Mem_Addr, Mem_DataW, Mem_RW
  );

  modport master (
    output Req, WE, Funct3, Addr, WData, Mem_DataR,
    input  Ready, Done, Fault, RData,
    input  Mem_Addr, Mem_DataW, Mem_RW
  );
endinterface

// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit in front of a word-wide, big-endian, registered-read DMEM.
// Sub-word stores are done as read-modify-write of the containing word.
module lsu_dmem_ctrl #(
  parameter int ADDR_MEM_WIDTH_LENGTH = 32
) (
  input  logic           Clk,
  input  logic           Rst_n,
  lsu_dmem_ctrl_if.slave bus
);
  localparam int AW = ADDR_MEM_WIDTH_LENGTH;

  typedef enum logic [2:0] {
    IDLE, READ, WAIT, WRITE, DONE
  } state_e;

  state_e        state_q, state_d;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic [15:0]   wlo_q;
  logic          fault_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   dataw_q;
  logic [31:0]   rdata_q;

  logic          accept;
  logic          f3_ok;
  logic          algn_ok;
  logic          req_ok;
  logic          is_sw;
  logic [7:0]    rd_b;
  logic [15:0]   rd_h;
  logic [31:0]   ld_ext;
  logic [31:0]   merged;

  assign accept = bus.Req && (state_q == IDLE);
  assign is_sw  = bus.WE && (bus.Funct3 == 3'd2);
  assign req_ok = f3_ok && algn_ok;

  always_comb begin
    if (bus.WE)
      f3_ok = bus.Funct3 inside {3'd0, 3'd1, 3'd2};
    else
      f3_ok = bus.Funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    unique case (bus.Funct3[1:0])
      2'd1:    algn_ok = ~bus.Addr[0];
      2'd2:    algn_ok = (bus.Addr[1:0] == 2'b00);
      default: algn_ok = 1'b1;
    endcase
  end

  // Byte k of a word sits at bits [31-8k -: 8]
  always_comb begin
    unique case (off_q)
      2'd0:    rd_b = bus.Mem_DataR[31:24];
      2'd1:    rd_b = bus.Mem_DataR[23:16];
      2'd2:    rd_b = bus.Mem_DataR[15:8];
      default: rd_b = bus.Mem_DataR[7:0];
    endcase
    rd_h = off_q[1] ? bus.Mem_DataR[15:0] : bus.Mem_DataR[31:16];

    ld_ext = bus.Mem_DataR;
    unique case (1'b1)
      f3_q == 3'd0: ld_ext = {{24{rd_b[7]}}, rd_b};
      f3_q == 3'd1: ld_ext = {{16{rd_h[15]}}, rd_h};
      f3_q == 3'd4: ld_ext = {24'h0, rd_b};
      f3_q == 3'd5: ld_ext = {16'h0, rd_h};
      default: ;
    endcase

    merged = bus.Mem_DataR;
    if (f3_q[0]) begin
      if (off_q[1]) merged[15:0]  = wlo_q;
      else          merged[31:16] = wlo_q;
    end else begin
      unique case (off_q)
        2'd0:    merged[31:24] = wlo_q[7:0];
        2'd1:    merged[23:16] = wlo_q[7:0];
        2'd2:    merged[15:8]  = wlo_q[7:0];
        default: merged[7:0]   = wlo_q[7:0];
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept)
               state_d = !req_ok ? DONE : is_sw ? WRITE : READ;
      READ:  state_d = WAIT;
      WAIT:  state_d = we_q ? WRITE : DONE;
      WRITE: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Mem_RW decodes state directly so reset drops it without a clock
  always_comb begin
    bus.Ready  = (state_q == IDLE);
    bus.Done   = (state_q == DONE);
    bus.Mem_RW = (state_q == WRITE);
    bus.Fault  = (state_q == DONE) && fault_q;
  end

  assign bus.RData     = rdata_q;
  assign bus.Mem_Addr  = addr_q;
  assign bus.Mem_DataW = dataw_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      wlo_q   <= 16'h0;
      fault_q <= 1'b0;
      addr_q  <= '0;
      dataw_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      if (accept) begin
        we_q    <= bus.WE;
        f3_q    <= bus.Funct3;
        off_q   <= bus.Addr[1:0];
        wlo_q   <= bus.WData[15:0];
        fault_q <= !req_ok;
        addr_q  <= {bus.Addr[AW-1:2], 2'b00};
        if (req_ok && is_sw) dataw_q <= bus.WData;
      end
      if (state_q == WAIT) begin
        if (we_q) dataw_q <= merged;
        else      rdata_q <= ld_ext;
      end
    end
  end
endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Bench for lsu_dmem_ctrl: byte-array reference model with per-cycle
// compare, directed literal cases, then randomized traffic.
module tb_lsu_dmem_ctrl;
  logic Clk;
  logic Rst_n;

  lsu_dmem_ctrl_if #(.AW(32)) bus ();

  lsu_dmem_ctrl #(.ADDR_MEM_WIDTH_LENGTH(32)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // DMEM: registered read, write at the end of a Mem_RW cycle
  logic [31:0] dmem   [1024];
  logic [31:0] init_w [1024];
  bit load_mem = 1'b1;

  always @(posedge Clk) begin
    if (load_mem) begin
      for (int i = 0; i < 1024; i++) dmem[i] <= init_w[i];
    end else if (bus.Mem_RW) begin
      dmem[bus.Mem_Addr[11:2]] <= bus.Mem_DataW;
    end
    bus.Mem_DataR <= dmem[bus.Mem_Addr[11:2]];
  end

  // Reference memory as plain bytes, byte 0 of a word is most significant
  logic [7:0] refm [4096];

  bit          busy = 1'b0;
  int          k = 0;
  int          dl = 0;
  bit          m_flt = 1'b0;
  bit          m_st = 1'b0;
  logic [2:0]  m_f3 = 3'd0;
  logic [11:0] m_a = 12'h0;
  logic [31:0] exp_rd = 32'h0;
  logic [31:0] exp_addr = 32'h0;
  logic [31:0] exp_ww = 32'h0;

  function automatic bit legal(input bit we, input logic [2:0] f3,
                               input logic [31:0] a);
    bit ok;
    int sz;
    if (we) ok = (f3 <= 3'd2);
    else    ok = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    sz = (f3 == 3'd2) ? 4 : ((f3 == 3'd1) || (f3 == 3'd5)) ? 2 : 1;
    return ok && ((int'(a[3:0]) % sz) == 0);
  endfunction

  function automatic logic [31:0] ref_word(input int base);
    return {refm[base], refm[base+1], refm[base+2], refm[base+3]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                           input logic [11:0] a);
    int ai;
    int v;
    logic [7:0]  b;
    logic [15:0] h;
    ai = int'(a);
    b  = refm[ai];
    h  = {refm[ai], refm[(ai + 1) % 4096]};
    case (f3)
      3'd0: begin v = $signed(b); return 32'(v); end
      3'd1: begin v = $signed(h); return 32'(v); end
      3'd2: return ref_word(ai);
      3'd4: return {24'h0, b};
      3'd5: return {16'h0, h};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_store_word(input logic [2:0] f3,
                                                 input logic [11:0] a,
                                                 input logic [31:0] wd);
    int ai;
    int base;
    logic [7:0] w [4];
    ai   = int'(a);
    base = ai - (ai % 4);
    for (int i = 0; i < 4; i++) w[i] = refm[base + i];
    case (f3)
      3'd0: w[ai % 4] = wd[7:0];
      3'd1: begin
        w[ai % 4]     = wd[15:8];
        w[ai % 4 + 1] = wd[7:0];
      end
      default: begin
        w[0] = wd[31:24];
        w[1] = wd[23:16];
        w[2] = wd[15:8];
        w[3] = wd[7:0];
      end
    endcase
    return {w[0], w[1], w[2], w[3]};
  endfunction

  // k counts edges since accept; Done is due dl edges after accept
  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      busy     = 1'b0;
      k        = 0;
      exp_rd   = 32'h0;
      exp_addr = 32'h0;
    end else if (busy) begin
      k = k + 1;
      if (k == dl && !m_flt) begin
        if (m_st) begin
          for (int i = 0; i < 4; i++)
            refm[int'(m_a & 12'hFFC) + i] = exp_ww[31-8*i -: 8];
        end else begin
          exp_rd = ref_load(m_f3, m_a);
        end
      end
      if (k > dl) busy = 1'b0;
    end else if (bus.Req) begin
      busy     = 1'b1;
      k        = 0;
      m_st     = bus.WE;
      m_f3     = bus.Funct3;
      m_a      = bus.Addr[11:0];
      m_flt    = !legal(bus.WE, bus.Funct3, bus.Addr);
      exp_addr = {bus.Addr[31:2], 2'b00};
      dl = m_flt ? 0 : !m_st ? 2 : (m_f3 == 3'd2) ? 1 : 3;
      if (m_st && !m_flt) exp_ww = ref_store_word(m_f3, m_a, bus.WData);
    end
  end

  always @(negedge Clk) begin : cmp
    bit e_done;
    bit e_rw;
    e_done = busy && (k == dl);
    e_rw   = busy && m_st && !m_flt && (k == dl - 1);
    chk("ready", 32'(bus.Ready), 32'(!busy));
    chk("done", 32'(bus.Done), 32'(e_done));
    chk("mem_rw", 32'(bus.Mem_RW), 32'(e_rw));
    chk("rdata", bus.RData, exp_rd);
    chk("mem_addr", bus.Mem_Addr, exp_addr);
    if (e_done) chk("fault", 32'(bus.Fault), 32'(m_flt));
    if (e_rw) chk("mem_dataw", bus.Mem_DataW, exp_ww);
    if (!Rst_n) chk("rst_dataw", bus.Mem_DataW, 32'h0);
  end

  task automatic txn(input string nm, input bit we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int e_lat, input bit e_flt, input int e_rw);
    int lat;
    int rw;
    bit flt;
    lat = 0;
    rw  = 0;
    flt = 1'b0;
    bus.Req    = 1'b1;
    bus.WE     = we;
    bus.Funct3 = f3;
    bus.Addr   = a;
    bus.WData  = wd;
    @(posedge Clk); #1;
    bus.Req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.Done) begin
        lat = i + 1;
        flt = bus.Fault;
        break;
      end
      if (bus.Mem_RW) rw++;
      @(posedge Clk); #1;
    end
    chk({nm, "_lat"}, 32'(lat), 32'(e_lat));
    chk({nm, "_fault"}, 32'(flt), 32'(e_flt));
    chk({nm, "_rwcyc"}, 32'(rw), 32'(e_rw));
    @(posedge Clk); #1;
  endtask

  task automatic rd_is(input string nm, input logic [31:0] lit);
    chk({nm, "_rdata"}, bus.RData, lit);
    chk({nm, "_model"}, exp_rd, lit);
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 10; i++) begin
      if (bus.Ready) break;
      @(posedge Clk); #1;
    end
    chk(nm, 32'(bus.Ready), 32'd1);
  endtask

  initial begin
    int nd;
    int d1;
    int d2;
    Rst_n      = 1'b0;
    bus.Req    = 1'b0;
    bus.WE     = 1'b0;
    bus.Funct3 = 3'd0;
    bus.Addr   = 32'h0;
    bus.WData  = 32'h0;
    for (int i = 0; i < 1024; i++) begin
      init_w[i] = $urandom;
      for (int j = 0; j < 4; j++) refm[4*i + j] = init_w[i][31-8*j -: 8];
    end
    @(posedge Clk); #1;
    load_mem = 1'b0;
    chk("rst_ready", 32'(bus.Ready), 32'd1);
    chk("rst_done", 32'(bus.Done), 32'd0);
    chk("rst_fault", 32'(bus.Fault), 32'd0);
    chk("rst_rw", 32'(bus.Mem_RW), 32'd0);
    chk("rst_rdata", bus.RData, 32'h0);
    chk("rst_maddr", bus.Mem_Addr, 32'h0);
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    @(posedge Clk); #1;

    txn("sw", 1'b1, 3'd2, 32'h200, 32'h80FF7F01, 2, 1'b0, 1);
    txn("lw", 1'b0, 3'd2, 32'h200, 32'h0, 3, 1'b0, 0);
    rd_is("lw", 32'h80FF7F01);
    txn("lb", 1'b0, 3'd0, 32'h200, 32'h0, 3, 1'b0, 0);
    rd_is("lb", 32'hFFFFFF80);
    txn("lbu", 1'b0, 3'd4, 32'h200, 32'h0, 3, 1'b0, 0);
    rd_is("lbu", 32'h00000080);
    txn("lh", 1'b0, 3'd1, 32'h200, 32'h0, 3, 1'b0, 0);
    rd_is("lh", 32'hFFFF80FF);
    txn("lhu", 1'b0, 3'd5, 32'h202, 32'h0, 3, 1'b0, 0);
    rd_is("lhu", 32'h00007F01);

    txn("sb", 1'b1, 3'd0, 32'h201, 32'h123456AB, 4, 1'b0, 1);
    txn("lw_sb", 1'b0, 3'd2, 32'h200, 32'h0, 3, 1'b0, 0);
    rd_is("lw_sb", 32'h80AB7F01);
    txn("sh", 1'b1, 3'd1, 32'h202, 32'h00001234, 4, 1'b0, 1);
    txn("lw_sh", 1'b0, 3'd2, 32'h200, 32'h0, 3, 1'b0, 0);
    rd_is("lw_sh", 32'h80AB1234);

    txn("lw_mis", 1'b0, 3'd2, 32'h202, 32'h0, 1, 1'b1, 0);
    rd_is("lw_mis", 32'h80AB1234);
    txn("sh_mis", 1'b1, 3'd1, 32'h203, 32'hFFFF, 1, 1'b1, 0);
    txn("ld_f3", 1'b0, 3'd3, 32'h200, 32'h0, 1, 1'b1, 0);
    txn("st_f3", 1'b1, 3'd4, 32'h200, 32'hAAAA, 1, 1'b1, 0);
    rd_is("flt_keep", 32'h80AB1234);
    chk("flt_mem", dmem[128], 32'h80AB1234);

    // Req held high: accepts land at edges 0, 4, 8
    nd = 0;
    d1 = 0;
    d2 = 0;
    bus.Req    = 1'b1;
    bus.WE     = 1'b0;
    bus.Funct3 = 3'd2;
    bus.Addr   = 32'h204;
    @(posedge Clk); #1;
    for (int j = 1; j <= 9; j++) begin
      @(posedge Clk); #1;
      if (bus.Done) begin
        nd++;
        if (nd == 1) d1 = j;
        else if (nd == 2) d2 = j;
      end
    end
    bus.Req = 1'b0;
    chk("b2b_count", 32'(nd), 32'd2);
    chk("b2b_first", 32'(d1), 32'd2);
    chk("b2b_second", 32'(d2), 32'd6);
    wait_idle("b2b_idle");

    // Reset in the WRITE cycle of an SB
    bus.Req    = 1'b1;
    bus.WE     = 1'b1;
    bus.Funct3 = 3'd0;
    bus.Addr   = 32'h200;
    bus.WData  = 32'h55;
    @(posedge Clk); #1;
    bus.Req = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    chk("mid_pre_rw", 32'(bus.Mem_RW), 32'd1);
    #2 Rst_n = 1'b0;
    #1;
    chk("mid_rw", 32'(bus.Mem_RW), 32'd0);
    chk("mid_ready", 32'(bus.Ready), 32'd1);
    chk("mid_done", 32'(bus.Done), 32'd0);
    chk("mid_rdata", bus.RData, 32'h0);
    chk("mid_maddr", bus.Mem_Addr, 32'h0);
    chk("mid_dataw", bus.Mem_DataW, 32'h0);
    @(posedge Clk); #1;
    chk("mid_done2", 32'(bus.Done), 32'd0);
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    @(posedge Clk); #1;
    chk("mid_mem", dmem[128], 32'h80AB1234);
    chk("mid_ref", ref_word(32'h200), 32'h80AB1234);
    chk("mid_ready2", 32'(bus.Ready), 32'd1);
    chk("mid_fault", 32'(bus.Fault), 32'd0);

    for (int c = 0; c < 1500; c++) begin
      bus.Req    = ($urandom_range(0, 9) < 6);
      bus.WE     = 1'($urandom_range(0, 1));
      bus.Funct3 = 3'($urandom_range(0, 7));
      bus.Addr   = 32'h100 + 32'($urandom_range(0, 63));
      bus.WData  = $urandom;
      @(posedge Clk); #1;
    end
    bus.Req = 1'b0;
    wait_idle("rand_idle");
    @(posedge Clk); #1;
    for (int i = 64; i < 80; i++)
      chk("mem_final", dmem[i], ref_word(4 * i));

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
